var_loader_multi: RTL and testbench
===================================

Name: var_loader_multi

Overview:
- Parametrised successor to the single-mode variance loader.
- For each of CORES detection windows it fetches the four corner samples (A, B, C, D) of the integral image and the squared-integral image. It then writes them into the per-core variance caches.
- Additions: configurable cache read latency, window X stride, read-grant stall handshake and a configuration-error exit.
- Sits between the window-scheduler control FSM and the shared integral/SQ cache read ports.

Parameters:
- CORES, 4, number of windows/cores loaded per start
- WINDOW_BLOCKING, 4, samples per cache block (power of 2)
- DATA_W, 32, integral sample width
- SQ_W, 48, squared-integral sample width
- Y_W, 10, Y address width
- X_W, 12, virtual X address width
- BLK_W, 10, block address width (X_W - log2(WINDOW_BLOCKING))
- WIN_W, 6, window size width
- STEP_W, 4, window stride width
- READ_LATENCY, 2, cycles from accepted request to valid cache q (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin load; sampled only in S_Ready
- start_y  in  Y_W  top row of first window
- start_block  in  BLK_W  block of first window
- win_size  in  WIN_W  window edge length
- step  in  STEP_W  X stride between consecutive cores' windows
- dbl_buf_in  in  1  double-buffer select, latched at start
- ack  in  1  releases S_Done
- ready  out  1  high in S_Ready
- done  out  1  high in S_Done
- cfg_err  out  1  high in S_Done when the run aborted for win_size<2
- rd_req  out  1  cache read request
- rd_y  out  Y_W  read row
- rd_block  out  BLK_W  read block
- rd_gnt  in  1  read accepted when rd_req&rd_gnt
- int_q  in  WINDOW_BLOCKING*DATA_W  integral block data
- sq_q  in  WINDOW_BLOCKING*SQ_W  squared block data
- vc_we  out  CORES  one-hot write enable (integral and SQ together)
- vc_waddr  out  2  corner index A=0 B=1 C=2 D=3
- vc_wdata  out  DATA_W  broadcast integral sample
- vc_wdata_sq  out  SQ_W  broadcast squared sample
- vc_dbl_buf  out  1  latched dbl_buf_in

Behaviour:
- Reset values:
  - FSM goes to S_Reset.
  - rd_req, vc_we, done, cfg_err, vc_dbl_buf = 0.
  - Addresses, vc_waddr and wdata = 0.
  - Pipeline valid bits cleared.
  - Reset mid-run produces no further writes.
- States and transitions:
  - S_Reset -> S_Ready.
  - S_Ready -> S_Load on start.
  - S_Load: latch ly=start_y+1, lx=start_block*WINDOW_BLOCKING+1, win, step, dbl_buf. Go to S_Done with cfg_err=1 if win_size<2, else S_Issue.
  - S_Issue: a 2-bit corner counter c and a window counter w advance on each accepted request. After c=3 with w=CORES-1, go to S_Drain.
  - S_Drain: wait until all pipeline valid bits are 0, then S_Done.
  - S_Done -> S_Reset on ack.
- Address generation in S_Issue (registered, held stable while rd_gnt=0):
  - X = lx + w*step + (c odd ? win-2 : 0).
  - Y = ly + (c>=2 ? win-2 : 0).
  - All arithmetic is modulo 2^X_W / 2^Y_W; no saturation.
  - rd_block = X / WINDOW_BLOCKING; element = X % WINDOW_BLOCKING.
- Pipeline:
  - {valid, element, c, w} are shifted READ_LATENCY stages from the accepting cycle.
  - At the final stage, the selected element of int_q/sq_q is registered.
  - vc_we[w] is a one-cycle pulse exactly READ_LATENCY+1 cycles after acceptance.
  - vc_waddr=c. All non-selected vc_we bits are 0.
- Stall: while rd_gnt=0, rd_req stays high with constant address and counters. In-flight requests still complete; the pipeline never stalls.
- start and ack are ignored outside S_Ready and S_Done respectively. ack asserted with the entry to S_Done is honoured the following cycle.
- Exactly 4*CORES writes per successful run, in order w-major, c-minor.

Decomposition:
- Package pkg_var_loader_multi holds:
  - STATES_t enum (S_Reset, S_Ready, S_Load, S_Issue, S_Drain, S_Done);
  - corner index constants;
  - a width helper function for BLK_W.
- One sub-module, var_loader_addr_gen: combinational X/Y/block/element from (lx, ly, win, step, w, c).

Test Plan:
- Configuration: CORES=4, WB=4, L=2, rd_gnt=1; start_y=10, start_block=3, win=24, step=1, start at cycle 0.
  - Expected addresses: core0 A=(y11, blk3, el1), B=(11, 8, 3), C=(33, 3, 1), D=(33, 8, 3); core3 A=(11, 4, 0).
  - Expected timing: 16 writes on cycles 5..20; done at cycle 21.
- Same stimulus with step=4: core2 A is X=21 -> blk5 el1, and D is X=43 -> blk10 el3.
- rd_gnt low for 5 cycles during core1 corner B: address held, no duplicate or missing write, total still 16, done delayed by 5.
- win_size=1: no rd_req, no vc_we, done and cfg_err high; ack returns to ready.
- reset asserted 2 cycles after the first accept: vc_we stays 0 thereafter; ready returns after reset deasserts.
- start held high in S_Done with ack low: remains in done; after ack, a new start begins a fresh run with dbl_buf re-latched.

Source files
------------

// File: rtl/var_loader_multi_pkg.sv
// Shared definitions for the multi-core variance loader.
// Contents:
//   - FSM state encoding (S_Reset .. S_Done) and its STATES_t type
//   - corner index constants (A=0, B=1, C=2, D=3)
//   - width helpers used to derive block and element address widths
package pkg_var_loader_multi;

  // State encoding kept as plain constants so legacy tools and waveform
  // viewers see stable values.
  typedef logic [2:0] STATES_t;

  localparam STATES_t S_Reset = 3'd0;
  localparam STATES_t S_Ready = 3'd1;
  localparam STATES_t S_Load  = 3'd2;
  localparam STATES_t S_Issue = 3'd3;
  localparam STATES_t S_Drain = 3'd4;
  localparam STATES_t S_Done  = 3'd5;

  // Corner index, also used directly as vc_waddr. Bit 0 selects the right
  // column (B, D), bit 1 selects the bottom row (C, D).
  localparam logic [1:0] CornerA = 2'd0;
  localparam logic [1:0] CornerB = 2'd1;
  localparam logic [1:0] CornerC = 2'd2;
  localparam logic [1:0] CornerD = 2'd3;

  // Block address width: virtual X address minus the in-block element bits.
  function automatic int unsigned blk_width(input int unsigned x_w, input int unsigned wb);
    return x_w - $clog2(wb);
  endfunction

  // $clog2 that never returns 0, for counter/index widths.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/var_loader_addr_gen.sv
// Combinational corner address generator.
// Given the latched window origin (lx_i, ly_i), window size, X stride, window
// index w_i and corner index c_i, produces the cache row, block and element:
//   X = lx + w*step + (c odd ? win-2 : 0)   (mod 2^X_W)
//   Y = ly + (c >= 2 ? win-2 : 0)           (mod 2^Y_W)
// Ports:
//   lx_i, ly_i   window origin (already offset by +1)
//   win_i        window edge length
//   step_i       X stride between consecutive windows
//   w_i, c_i     window and corner index
//   y_o          cache row
//   block_o      X / WINDOW_BLOCKING
//   elem_o       X % WINDOW_BLOCKING
module var_loader_addr_gen
  import pkg_var_loader_multi::*;
#(
  parameter int unsigned WINDOW_BLOCKING = 4,
  parameter int unsigned Y_W             = 10,
  parameter int unsigned X_W             = 12,
  parameter int unsigned BLK_W           = 10,
  parameter int unsigned WIN_W           = 6,
  parameter int unsigned STEP_W          = 4,
  parameter int unsigned W_W             = 2,
  parameter int unsigned EL_W            = 2
) (
  input  logic [X_W-1:0]    lx_i,
  input  logic [Y_W-1:0]    ly_i,
  input  logic [WIN_W-1:0]  win_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [W_W-1:0]    w_i,
  input  logic [1:0]        c_i,
  output logic [Y_W-1:0]    y_o,
  output logic [BLK_W-1:0]  block_o,
  output logic [EL_W-1:0]   elem_o
);

  localparam int unsigned ElShift = clog2_min1(WINDOW_BLOCKING);

  logic [X_W-1:0] w_x;
  logic [X_W-1:0] step_x;
  logic [X_W-1:0] win_x;
  logic [X_W-1:0] off_x;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] win_y;
  logic [Y_W-1:0] off_y;

  // All sums wrap at the address width; out-of-range windows alias rather
  // than saturate.
  always_comb begin
    w_x    = X_W'(w_i);
    step_x = X_W'(step_i);
    win_x  = X_W'(win_i) - X_W'(2);
    win_y  = Y_W'(win_i) - Y_W'(2);
    off_x  = c_i[0] ? win_x : '0;
    off_y  = c_i[1] ? win_y : '0;
    x      = lx_i + (w_x * step_x) + off_x;
    y_o    = ly_i + off_y;
  end

  assign block_o = BLK_W'(x >> ElShift);
  assign elem_o  = EL_W'(x);

endmodule

// File: rtl/var_loader_multi.sv
// Multi-core variance loader.
// For each of CORES detection windows, reads the four corner samples (A, B,
// C, D) of the integral and squared-integral images from the shared cache
// read port and writes them into the per-core variance caches.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, ack          begin a load (in S_Ready) / release S_Done
//   start_y, start_block, win_size, step, dbl_buf_in
//                       run configuration, latched in S_Load
//   ready, done, cfg_err
//                       status; cfg_err flags a run aborted for win_size < 2
//   rd_req, rd_y, rd_block, rd_gnt
//                       cache read request, accepted on rd_req & rd_gnt
//   int_q, sq_q         cache block data, valid READ_LATENCY cycles after accept
//   vc_we, vc_waddr, vc_wdata, vc_wdata_sq, vc_dbl_buf
//                       variance cache write port (one-hot per core)
module var_loader_multi
  import pkg_var_loader_multi::*;
#(
  parameter int unsigned CORES           = 4,
  parameter int unsigned WINDOW_BLOCKING = 4,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned SQ_W            = 48,
  parameter int unsigned Y_W             = 10,
  parameter int unsigned X_W             = 12,
  parameter int unsigned BLK_W           = blk_width(X_W, WINDOW_BLOCKING),
  parameter int unsigned WIN_W           = 6,
  parameter int unsigned STEP_W          = 4,
  parameter int unsigned READ_LATENCY    = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [Y_W-1:0]                    start_y,
  input  logic [BLK_W-1:0]                  start_block,
  input  logic [WIN_W-1:0]                  win_size,
  input  logic [STEP_W-1:0]                 step,
  input  logic                              dbl_buf_in,
  input  logic                              ack,
  output logic                              ready,
  output logic                              done,
  output logic                              cfg_err,
  output logic                              rd_req,
  output logic [Y_W-1:0]                    rd_y,
  output logic [BLK_W-1:0]                  rd_block,
  input  logic                              rd_gnt,
  input  logic [WINDOW_BLOCKING*DATA_W-1:0] int_q,
  input  logic [WINDOW_BLOCKING*SQ_W-1:0]   sq_q,
  output logic [CORES-1:0]                  vc_we,
  output logic [1:0]                        vc_waddr,
  output logic [DATA_W-1:0]                 vc_wdata,
  output logic [SQ_W-1:0]                   vc_wdata_sq,
  output logic                              vc_dbl_buf
);

  localparam int unsigned W_W  = clog2_min1(CORES);
  localparam int unsigned EL_W = clog2_min1(WINDOW_BLOCKING);
  localparam int unsigned L    = READ_LATENCY;

  // Control state
  STATES_t             state_q, state_d;
  logic [Y_W-1:0]      ly_q, ly_d;
  logic [X_W-1:0]      lx_q, lx_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                dbl_buf_q, dbl_buf_d;
  logic                cfg_err_q, cfg_err_d;
  logic [1:0]          c_q, c_d;
  logic [W_W-1:0]      w_q, w_d;

  // Registered request address
  logic [Y_W-1:0]      rd_y_q;
  logic [BLK_W-1:0]    rd_block_q;
  logic [EL_W-1:0]     rd_el_q;
  logic                addr_load;

  logic [Y_W-1:0]      gen_y;
  logic [BLK_W-1:0]    gen_block;
  logic [EL_W-1:0]     gen_el;

  // Read-latency pipeline
  logic [L-1:0]        pv_q;
  logic [EL_W-1:0]     pe_q [L];
  logic [1:0]          pc_q [L];
  logic [W_W-1:0]      pw_q [L];

  // Write port registers
  logic [CORES-1:0]    vc_we_q, vc_we_d;
  logic [1:0]          vc_waddr_q;
  logic [DATA_W-1:0]   vc_wdata_q, sel_int;
  logic [SQ_W-1:0]     vc_wdata_sq_q, sel_sq;

  logic accept;
  logic last_req;

  assign accept   = (state_q == S_Issue) && rd_gnt;
  assign last_req = (c_q == CornerD) && (w_q == W_W'(CORES - 1));

  // Next-state and configuration latch. The address generator always sees the
  // *_d values, so the address of the next request is ready the same edge the
  // counters advance (and in S_Load, the first request's address).
  always_comb begin
    state_d   = state_q;
    ly_d      = ly_q;
    lx_d      = lx_q;
    win_d     = win_q;
    step_d    = step_q;
    dbl_buf_d = dbl_buf_q;
    cfg_err_d = cfg_err_q;
    c_d       = c_q;
    w_d       = w_q;
    addr_load = 1'b0;

    case (state_q)
      S_Reset: state_d = S_Ready;
      S_Ready: begin
        if (start) state_d = S_Load;
      end
      S_Load: begin
        ly_d      = start_y + Y_W'(1);
        lx_d      = X_W'({start_block, {EL_W{1'b0}}}) + X_W'(1);
        win_d     = win_size;
        step_d    = step;
        dbl_buf_d = dbl_buf_in;
        c_d       = '0;
        w_d       = '0;
        if (win_size < WIN_W'(2)) begin
          cfg_err_d = 1'b1;
          state_d   = S_Done;
        end else begin
          cfg_err_d = 1'b0;
          addr_load = 1'b1;
          state_d   = S_Issue;
        end
      end
      S_Issue: begin
        if (rd_gnt) begin
          c_d       = c_q + 2'd1;
          addr_load = 1'b1;
          if (c_q == CornerD) w_d = w_q + W_W'(1);
          if (last_req) state_d = S_Drain;
        end
      end
      S_Drain: begin
        if (pv_q == '0) state_d = S_Done;
      end
      S_Done: begin
        if (ack) begin
          cfg_err_d = 1'b0;
          state_d   = S_Reset;
        end
      end
      default: state_d = S_Reset;
    endcase
  end

  var_loader_addr_gen #(
    .WINDOW_BLOCKING (WINDOW_BLOCKING),
    .Y_W             (Y_W),
    .X_W             (X_W),
    .BLK_W           (BLK_W),
    .WIN_W           (WIN_W),
    .STEP_W          (STEP_W),
    .W_W             (W_W),
    .EL_W            (EL_W)
  ) u_addr_gen (
    .lx_i    (lx_d),
    .ly_i    (ly_d),
    .win_i   (win_d),
    .step_i  (step_d),
    .w_i     (w_d),
    .c_i     (c_d),
    .y_o     (gen_y),
    .block_o (gen_block),
    .elem_o  (gen_el)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_Reset;
      ly_q       <= '0;
      lx_q       <= '0;
      win_q      <= '0;
      step_q     <= '0;
      dbl_buf_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      c_q        <= '0;
      w_q        <= '0;
      rd_y_q     <= '0;
      rd_block_q <= '0;
      rd_el_q    <= '0;
    end else begin
      state_q   <= state_d;
      ly_q      <= ly_d;
      lx_q      <= lx_d;
      win_q     <= win_d;
      step_q    <= step_d;
      dbl_buf_q <= dbl_buf_d;
      cfg_err_q <= cfg_err_d;
      c_q       <= c_d;
      w_q       <= w_d;
      // Address only moves on acceptance, so it is stable through a stall.
      if (addr_load) begin
        rd_y_q     <= gen_y;
        rd_block_q <= gen_block;
        rd_el_q    <= gen_el;
      end
    end
  end

  // Tag pipeline: never stalls, so in-flight reads complete during rd_gnt=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < L; i++) begin
        pe_q[i] <= '0;
        pc_q[i] <= '0;
        pw_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= accept;
      pe_q[0] <= rd_el_q;
      pc_q[0] <= c_q;
      pw_q[0] <= w_q;
      for (int unsigned i = 1; i < L; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pc_q[i] <= pc_q[i-1];
        pw_q[i] <= pw_q[i-1];
      end
    end
  end

  // Element select from the block returned by the cache at the final stage.
  always_comb begin
    sel_int = '0;
    sel_sq  = '0;
    for (int unsigned i = 0; i < WINDOW_BLOCKING; i++) begin
      if (pe_q[L-1] == EL_W'(i)) begin
        sel_int = int_q[i*DATA_W +: DATA_W];
        sel_sq  = sq_q[i*SQ_W +: SQ_W];
      end
    end
  end

  always_comb begin
    vc_we_d = '0;
    if (pv_q[L-1]) vc_we_d = CORES'(1) << pw_q[L-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vc_we_q       <= '0;
      vc_waddr_q    <= '0;
      vc_wdata_q    <= '0;
      vc_wdata_sq_q <= '0;
    end else begin
      vc_we_q <= vc_we_d;
      if (pv_q[L-1]) begin
        vc_waddr_q    <= pc_q[L-1];
        vc_wdata_q    <= sel_int;
        vc_wdata_sq_q <= sel_sq;
      end
    end
  end

  assign ready       = (state_q == S_Ready);
  assign done        = (state_q == S_Done);
  assign cfg_err     = cfg_err_q && (state_q == S_Done);
  assign rd_req      = (state_q == S_Issue);
  assign rd_y        = rd_y_q;
  assign rd_block    = rd_block_q;
  assign vc_we       = vc_we_q;
  assign vc_waddr    = vc_waddr_q;
  assign vc_wdata    = vc_wdata_q;
  assign vc_wdata_sq = vc_wdata_sq_q;
  assign vc_dbl_buf  = dbl_buf_q;

endmodule

// File: tb/tb_var_loader_multi.sv
// Self-checking bench for var_loader_multi (CORES=4, WINDOW_BLOCKING=4, L=2).
module tb_var_loader_multi;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [9:0]    start_y = '0;
  logic [9:0]    start_block = '0;
  logic [5:0]    win_size = '0;
  logic [3:0]    step = '0;
  logic          dbl_buf_in = 1'b0;
  logic          ack = 1'b0;
  logic          ready, done, cfg_err, rd_req;
  logic [9:0]    rd_y, rd_block;
  logic          rd_gnt = 1'b1;
  logic [127:0]  int_q;
  logic [191:0]  sq_q;
  logic [3:0]    vc_we;
  logic [1:0]    vc_waddr;
  logic [31:0]   vc_wdata;
  logic [47:0]   vc_wdata_sq;
  logic          vc_dbl_buf;

  var_loader_multi #(
    .CORES           (4),
    .WINDOW_BLOCKING (4),
    .DATA_W          (32),
    .SQ_W            (48),
    .Y_W             (10),
    .X_W             (12),
    .BLK_W           (10),
    .WIN_W           (6),
    .STEP_W          (4),
    .READ_LATENCY    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_y     (start_y),
    .start_block (start_block),
    .win_size    (win_size),
    .step        (step),
    .dbl_buf_in  (dbl_buf_in),
    .ack         (ack),
    .ready       (ready),
    .done        (done),
    .cfg_err     (cfg_err),
    .rd_req      (rd_req),
    .rd_y        (rd_y),
    .rd_block    (rd_block),
    .rd_gnt      (rd_gnt),
    .int_q       (int_q),
    .sq_q        (sq_q),
    .vc_we       (vc_we),
    .vc_waddr    (vc_waddr),
    .vc_wdata    (vc_wdata),
    .vc_wdata_sq (vc_wdata_sq),
    .vc_dbl_buf  (vc_dbl_buf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cyc = -1;
  int req_cnt = 0;
  bit stall_on = 1'b0;

  typedef struct {
    int          cyc;
    logic [3:0]  we;
    logic [1:0]  addr;
    logic [31:0] d;
    logic [47:0] sq;
  } wr_t;
  wr_t wq[$];
  logic [19:0] stall_addr[$];

  typedef struct {
    logic [9:0] sy;
    logic [9:0] sblk;
    logic [5:0] win;
    logic [3:0] step;
    logic       dbl;
    bit         stall;
    int         exp_done;
  } run_t;
  run_t runs[5];

  // Cache sample tag: row, block and element all recoverable from the data.
  function automatic logic [31:0] sample(input logic [9:0] y, input logic [9:0] b, input int e);
    logic [7:0] e8;
    e8 = e[7:0];
    return {2'b10, y, b, e8, 2'b01};
  endfunction

  function automatic logic [47:0] sq_sample(input logic [9:0] y, input logic [9:0] b,
                                            input int e);
    return {16'h5A3C, ~sample(y, b, e)};
  endfunction

  // Cache model: data for an address appears two cycles after it is presented.
  logic [9:0] cy_q[2];
  logic [9:0] cb_q[2];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    cy_q[0] <= rd_y;
    cb_q[0] <= rd_block;
    cy_q[1] <= cy_q[0];
    cb_q[1] <= cb_q[0];
  end

  always_comb begin
    int_q = '0;
    sq_q  = '0;
    for (int i = 0; i < 4; i++) begin
      int_q[i*32 +: 32] = sample(cy_q[1], cb_q[1], i);
      sq_q[i*48 +: 48]  = sq_sample(cy_q[1], cb_q[1], i);
    end
  end

  // Grant driver and output monitor, both away from the active edge.
  always @(negedge clk) begin
    int n;
    n = cyc - t0;
    rd_gnt = !(stall_on && n >= 7 && n < 12);
    if (vc_we != 4'd0) wq.push_back('{n, vc_we, vc_waddr, vc_wdata, vc_wdata_sq});
    if (rd_req) req_cnt++;
    if (rd_req && !rd_gnt) stall_addr.push_back({rd_y, rd_block});
    if (done && done_cyc < 0) done_cyc = n;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int k);
    if (k < wq.size()) return wq[k].d;
    return '0;
  endfunction

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cyc < 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cyc < 0) chk({name, " done timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready"}, 64'(ready), 64'd1);
  endtask

  task automatic begin_run(input logic [9:0] sy, input logic [9:0] sb, input logic [5:0] w,
                           input logic [3:0] st, input logic db, input bit stl);
    @(negedge clk);
    start_y     = sy;
    start_block = sb;
    win_size    = w;
    step        = st;
    dbl_buf_in  = db;
    stall_on    = stl;
    t0          = cyc;
    done_cyc    = -1;
    req_cnt     = 0;
    wq.delete();
    stall_addr.delete();
    start       = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic check_run(input int idx);
    run_t r;
    string nm;
    logic [11:0] x;
    logic [9:0]  y;
    int          acc;
    r  = runs[idx];
    nm = $sformatf("run%0d", idx);
    chk({nm, " done cycle"}, 64'(done_cyc), 64'(r.exp_done));
    chk({nm, " write count"}, 64'(wq.size()), 64'd16);
    chk({nm, " req cycles"}, 64'(req_cnt), 64'(r.stall ? 21 : 16));
    chk({nm, " dbl_buf"}, 64'(vc_dbl_buf), 64'(r.dbl));
    chk({nm, " cfg_err"}, 64'(cfg_err), 64'd0);
    for (int k = 0; k < 16 && k < wq.size(); k++) begin
      int w, c;
      w   = k / 4;
      c   = k % 4;
      x   = {r.sblk, 2'b00} + 12'd1 + 12'(w) * 12'(r.step)
            + (c % 2 == 1 ? 12'(r.win) - 12'd2 : 12'd0);
      y   = r.sy + 10'd1 + (c >= 2 ? 10'(r.win) - 10'd2 : 10'd0);
      acc = 2 + k + ((r.stall && k >= 5) ? 5 : 0);
      chk($sformatf("%s wr%0d cycle", nm, k), 64'(wq[k].cyc), 64'(acc + 3));
      chk($sformatf("%s wr%0d we", nm, k), 64'(wq[k].we), 64'(4'b0001 << w));
      chk($sformatf("%s wr%0d waddr", nm, k), 64'(wq[k].addr), 64'(c));
      chk($sformatf("%s wr%0d data", nm, k), 64'(wq[k].d), 64'(sample(y, x[11:2], int'(x[1:0]))));
      chk($sformatf("%s wr%0d sq", nm, k), 64'(wq[k].sq), 64'(sq_sample(y, x[11:2], int'(x[1:0]))));
    end
    if (r.stall) begin
      chk({nm, " stall len"}, 64'(stall_addr.size()), 64'd5);
      // Core 1 corner B: X = 13 + 1 + 22 = 36 -> block 9, row 11.
      foreach (stall_addr[i]) chk($sformatf("%s stall addr%0d", nm, i), 64'(stall_addr[i]),
                                  64'({10'd11, 10'd9}));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //           sy       sblk      win    step  dbl   stall done
    runs[0] = '{10'd10,   10'd3,    6'd24, 4'd1, 1'b1, 1'b0, 21};
    runs[1] = '{10'd10,   10'd3,    6'd24, 4'd4, 1'b0, 1'b0, 21};
    runs[2] = '{10'd10,   10'd3,    6'd24, 4'd1, 1'b1, 1'b1, 26};
    runs[3] = '{10'd1020, 10'd1023, 6'd9,  4'd3, 1'b1, 1'b0, 21};
    runs[4] = '{10'd0,    10'd0,    6'd2,  4'd0, 1'b0, 1'b0, 21};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst cfg_err", 64'(cfg_err), 64'd0);
    chk("rst rd_req", 64'(rd_req), 64'd0);
    chk("rst vc_we", 64'(vc_we), 64'd0);
    chk("rst dbl_buf", 64'(vc_dbl_buf), 64'd0);
    chk("rst addr", 64'({rd_y, rd_block, vc_waddr}), 64'd0);
    chk("rst wdata", 64'({vc_wdata, vc_wdata_sq}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst ready after", 64'(ready), 64'd1);

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      wait_ready($sformatf("run%0d pre", i));
      begin_run(runs[i].sy, runs[i].sblk, runs[i].win, runs[i].step, runs[i].dbl, runs[i].stall);
      @(negedge clk);
      start = 1'b0;
      wait_done($sformatf("run%0d", i));
      check_run(i);
      if (i == 0) begin
        chk("run0 A core0", 64'(wd(0)), 64'(sample(10'd11, 10'd3, 1)));
        chk("run0 B core0", 64'(wd(1)), 64'(sample(10'd11, 10'd8, 3)));
        chk("run0 C core0", 64'(wd(2)), 64'(sample(10'd33, 10'd3, 1)));
        chk("run0 D core0", 64'(wd(3)), 64'(sample(10'd33, 10'd8, 3)));
        chk("run0 A core3", 64'(wd(12)), 64'(sample(10'd11, 10'd4, 0)));
      end
      if (i == 1) begin
        chk("run1 A core2", 64'(wd(8)), 64'(sample(10'd11, 10'd5, 1)));
        chk("run1 D core2", 64'(wd(11)), 64'(sample(10'd33, 10'd10, 3)));
      end
      if (i == 3) begin
        chk("run3 X wrap", 64'(wd(4)), 64'(sample(10'd1021, 10'd0, 0)));
        chk("run3 XY wrap", 64'(wd(14)), 64'(sample(10'd4, 10'd1, 2)));
      end
      stall_on = 1'b0;
      pulse_ack();
    end

    // win_size = 1: configuration error exit, ack on entry to S_Done
    wait_ready("cfg pre");
    begin_run(10'd10, 10'd3, 6'd1, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 20 && !done; n++) @(negedge clk);
    chk("cfg done cycle", 64'(cyc - t0), 64'd2);
    chk("cfg cfg_err", 64'(cfg_err), 64'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("cfg ack next cycle", 64'(done), 64'd0);
    chk("cfg no req", 64'(req_cnt), 64'd0);
    chk("cfg no write", 64'(wq.size()), 64'd0);
    wait_ready("cfg post");
    chk("cfg err cleared", 64'(cfg_err), 64'd0);

    // Reset two cycles after the first accept
    begin_run(10'd10, 10'd3, 6'd24, 4'd1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_ready("midrst");
    repeat (15) @(negedge clk);
    chk("midrst no write", 64'(wq.size()), 64'd0);
    chk("midrst idle", 64'({done, rd_req}), 64'd0);

    // start held through S_Done, then a fresh run after ack
    wait_ready("hold pre");
    begin_run(10'd10, 10'd3, 6'd24, 4'd1, 1'b1, 1'b0);
    wait_done("hold run1");
    repeat (5) @(negedge clk);
    chk("hold stays done", 64'(done), 64'd1);
    chk("hold writes", 64'(wq.size()), 64'd16);
    chk("hold dbl first", 64'(vc_dbl_buf), 64'd1);
    dbl_buf_in = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    wq.delete();
    done_cyc = -1;
    wait_done("hold run2");
    start = 1'b0;
    chk("hold fresh writes", 64'(wq.size()), 64'd16);
    chk("hold fresh first", 64'(wd(0)), 64'(sample(10'd11, 10'd3, 1)));
    chk("hold dbl relatched", 64'(vc_dbl_buf), 64'd0);
    pulse_ack();
    wait_ready("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
